float_copro_arbiter: RTL and testbench

- Shares one float_copro instance between NREQ requesters (CPU pipes or DMA-style engines).
- Grants one request at a time with round-robin priority and registers the winner's opcode and operands.
- Drives the coprocessor valid/complete/accept handshake, returns the result to the winner, and guarantees a valid-low gap between operations.

---
 rtl/float_copro_pkg.sv | 16 +
 rtl/float_rr_pick.sv | 32 +++
 rtl/float_copro_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_float_copro_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_copro_pkg.sv
// Shared widths, FSM state encoding and constants for the float_copro arbiter.
package float_copro_pkg;

   localparam int OPC_W  = 11;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE,
      RESP
   } arb_state_t;

endpackage

// File: rtl/float_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, with wrap-around.
module float_rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
)(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand [NREQ];

   // cand[k] is the k-th requester in priority order after rr_ptr
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand[gi] = IDX_W'((int'(rr_ptr) + gi + 1) % NREQ);
      end
   endgenerate

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            found = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one float_copro between NREQ requesters.
// Optional ISSUE timeout abort is enabled by defining FLOAT_COPRO_ARB_TIMEOUT_EN.
module float_copro_arbiter
   import float_copro_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*OPC_W-1:0]  req_opcode,
   input  logic [NREQ*DATA_W-1:0] req_op0,
   input  logic [NREQ*DATA_W-1:0] req_op1,
   input  logic [NREQ-1:0]        req_accept,
   output logic [NREQ-1:0]        req_complete,
   output logic [DATA_W-1:0]      req_result,
   output logic [NREQ-1:0]        req_error,
   output logic                   copro_valid,
   output logic [OPC_W-1:0]       copro_opcode,
   output logic [DATA_W-1:0]      copro_op0,
   output logic [DATA_W-1:0]      copro_op1,
   output logic                   copro_accept,
   input  logic                   copro_complete,
   input  logic [DATA_W-1:0]      copro_result
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   generate
      if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
         $error("float_copro_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
      end
   endgenerate

   arb_state_t       state_reg, state_next;
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [IDX_W-1:0] grant_reg, grant_next;
   logic [OPC_W-1:0] opcode_reg, opcode_next;
   logic [DATA_W-1:0] op0_reg, op0_next, op1_reg, op1_next;
   logic [DATA_W-1:0] result_reg, result_next, resp_reg, resp_next;
   logic             valid_reg, valid_next, accept_reg, accept_next;
   logic [NREQ-1:0]  complete_reg, complete_next;
   logic [NREQ-1:0]  grant_onehot;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;

   logic [OPC_W-1:0]  opc_arr [NREQ];
   logic [DATA_W-1:0] op0_arr [NREQ];
   logic [DATA_W-1:0] op1_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign opc_arr[gi] = req_opcode[gi*OPC_W +: OPC_W];
         assign op0_arr[gi] = req_op0[gi*DATA_W +: DATA_W];
         assign op1_arr[gi] = req_op1[gi*DATA_W +: DATA_W];
      end
   endgenerate

   float_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_reg),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   assign grant_onehot = NREQ'(1) << grant_reg;

`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             timeout_reg, timeout_next;
   logic [NREQ-1:0]  error_reg, error_next;
`endif

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      grant_next    = grant_reg;
      opcode_next   = opcode_reg;
      op0_next      = op0_reg;
      op1_next      = op1_reg;
      result_next   = result_reg;
      resp_next     = resp_reg;
      valid_next    = valid_reg;
      accept_next   = accept_reg;
      complete_next = complete_reg;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
      cnt_next      = cnt_reg;
      timeout_next  = timeout_reg;
      error_next    = error_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               grant_next  = pick_idx;
               rr_ptr_next = pick_idx;
               opcode_next = opc_arr[pick_idx];
               op0_next    = op0_arr[pick_idx];
               op1_next    = op1_arr[pick_idx];
               valid_next  = 1'b1;
               state_next  = ISSUE;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
               cnt_next     = '0;
               timeout_next = 1'b0;
`endif
            end
         end
         ISSUE: begin
            if (copro_complete) begin
               result_next = copro_result;
               accept_next = 1'b1;
               state_next  = DONE;
            end
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
            // Dropping valid aborts and resets the coprocessor
            else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
               valid_next   = 1'b0;
               result_next  = QNAN;
               timeout_next = 1'b1;
               state_next   = DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            valid_next  = 1'b0;
            accept_next = 1'b0;
            if (req_valid[grant_reg]) begin
               complete_next = grant_onehot;
               resp_next     = result_reg;
               state_next    = RESP;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
               error_next    = timeout_reg ? grant_onehot : '0;
`endif
            end else begin
               state_next = IDLE;
            end
         end
         RESP: begin
            if (!req_valid[grant_reg] || req_accept[grant_reg]) begin
               complete_next = '0;
               state_next    = IDLE;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
               error_next    = '0;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= IDX_W'(NREQ - 1);
         grant_reg    <= '0;
         opcode_reg   <= '0;
         op0_reg      <= '0;
         op1_reg      <= '0;
         result_reg   <= '0;
         resp_reg     <= '0;
         valid_reg    <= 1'b0;
         accept_reg   <= 1'b0;
         complete_reg <= '0;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
         cnt_reg      <= '0;
         timeout_reg  <= 1'b0;
         error_reg    <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         grant_reg    <= grant_next;
         opcode_reg   <= opcode_next;
         op0_reg      <= op0_next;
         op1_reg      <= op1_next;
         result_reg   <= result_next;
         resp_reg     <= resp_next;
         valid_reg    <= valid_next;
         accept_reg   <= accept_next;
         complete_reg <= complete_next;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
         cnt_reg      <= cnt_next;
         timeout_reg  <= timeout_next;
         error_reg    <= error_next;
`endif
      end
   end

   assign copro_valid  = valid_reg;
   assign copro_accept = accept_reg;
   assign copro_opcode = opcode_reg;
   assign copro_op0    = op0_reg;
   assign copro_op1    = op1_reg;
   assign req_complete = complete_reg;
   assign req_result   = resp_reg;
`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
   assign req_error    = error_reg;
`else
   assign req_error    = '0;
`endif

endmodule

// File: tb/tb_float_copro_arbiter.sv
// Scoreboard bench for float_copro_arbiter with a stub coprocessor (result = op0 + op1 + opcode).
module tb_float_copro_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 3;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      rv = '0;
   logic [NREQ-1:0]      racc = '0;
   logic [10:0]          opc [NREQ];
   logic [31:0]          a [NREQ];
   logic [31:0]          b [NREQ];
   int                   pend [NREQ];
   logic [NREQ*11-1:0]   req_opcode;
   logic [NREQ*32-1:0]   req_op0, req_op1;
   logic [NREQ-1:0]      req_complete, req_error;
   logic [31:0]          req_result;
   logic                 copro_valid, copro_accept;
   logic [10:0]          copro_opcode;
   logic [31:0]          copro_op0, copro_op1;
   logic                 copro_complete = 1'b0;
   logic [31:0]          copro_result = '0;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   cmp_cyc = 0;
   int   accept_count = 0;
   logic stuck = 1'b0;
   exp_t sb [$];

   assign req_opcode = {opc[3], opc[2], opc[1], opc[0]};
   assign req_op0    = {a[3], a[2], a[1], a[0]};
   assign req_op1    = {b[3], b[2], b[1], b[0]};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   float_copro_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (rv),
      .req_opcode     (req_opcode),
      .req_op0        (req_op0),
      .req_op1        (req_op1),
      .req_accept     (racc),
      .req_complete   (req_complete),
      .req_result     (req_result),
      .req_error      (req_error),
      .copro_valid    (copro_valid),
      .copro_opcode   (copro_opcode),
      .copro_op0      (copro_op0),
      .copro_op1      (copro_op1),
      .copro_accept   (copro_accept),
      .copro_complete (copro_complete),
      .copro_result   (copro_result)
   );

   // Stub coprocessor: completes LAT cycles after valid, holds complete until accept
   initial begin
      int cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || !copro_valid) begin
            cnt = 0;
            copro_complete = 1'b0;
         end else if (copro_accept) begin
            cnt = 0;
            copro_complete = 1'b0;
            accept_count++;
         end else if (!copro_complete && !stuck) begin
            cnt++;
            if (cnt == LAT) begin
               copro_complete = 1'b1;
               copro_result = copro_op0 + copro_op1 + 32'(copro_opcode);
               cmp_cyc = cyc;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each new req_complete
   initial begin
      logic [NREQ-1:0] prev_c = '0;
      logic            prev_a = 1'b0;
      exp_t            e;
      logic [NREQ-1:0] oh;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_c = '0;
            prev_a = 1'b0;
         end else begin
            if (prev_a) begin
               checks++;
               if (copro_valid !== 1'b0 || copro_accept !== 1'b0) begin
                  failures++;
                  $display("FAIL gap: valid=%b accept=%b required 0 0", copro_valid, copro_accept);
               end
            end
            if (req_complete !== '0 && prev_c === '0) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_complete: req_complete=%b required none", req_complete);
               end else begin
                  e = sb.pop_front();
                  oh = NREQ'(1) << e.idx;
                  $display("txn req=%0d complete=%b result=%h error=%b", e.idx, req_complete, req_result, req_error);
                  if (req_complete !== oh) begin
                     failures++;
                     $display("FAIL grant: req_complete=%b required %b", req_complete, oh);
                  end
                  checks++;
                  if (req_result !== e.res) begin
                     failures++;
                     $display("FAIL result: req_result=%h required %h", req_result, e.res);
                  end
                  checks++;
                  if (req_error !== (e.err ? oh : '0)) begin
                     failures++;
                     $display("FAIL error: req_error=%b required %b", req_error, e.err ? oh : '0);
                  end
                  if (!e.err) begin
                     checks++;
                     if (cyc != cmp_cyc + 2) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles required 2", cyc - cmp_cyc);
                     end
                  end
               end
            end
            prev_c = req_complete;
            prev_a = copro_accept;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish required finish");
      $fatal(1, "watchdog");
   end

   task automatic respond();
      for (int i = 0; i < NREQ; i++) begin
         if (racc[i]) begin
            racc[i] = 1'b0;
         end else if (req_complete[i] && rv[i]) begin
            racc[i] = 1'b1;
            pend[i]--;
            if (pend[i] <= 0) rv[i] = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      respond();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((sb.size() != 0 || rv != '0 || racc != '0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0 || rv != '0) begin
         failures++;
         $display("FAIL %s_drain: pending=%0d required 0", name, sb.size());
      end
      repeat (3) step();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (copro_valid !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      check({name, "_valid"}, 32'(copro_valid), 32'd1);
   endtask

   task automatic setreq(input int i, input logic [10:0] o, input logic [31:0] x, input logic [31:0] y, input int n);
      opc[i]  = o;
      a[i]    = x;
      b[i]    = y;
      pend[i] = n;
   endtask

   task automatic push(input int i, input logic [31:0] r, input logic e);
      exp_t t;
      t.idx = i;
      t.res = r;
      t.err = e;
      sb.push_back(t);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int acc0;
      int n;
      int bad;
      for (int i = 0; i < NREQ; i++) begin
         opc[i] = '0; a[i] = '0; b[i] = '0; pend[i] = 0;
      end
      do_reset();

      // Reset state
      check("rst_valid",    32'(copro_valid),  32'd0);
      check("rst_accept",   32'(copro_accept), 32'd0);
      check("rst_complete", 32'(req_complete), 32'd0);
      check("rst_error",    32'(req_error),    32'd0);
      check("rst_opcode",   32'(copro_opcode), 32'd0);
      check("rst_op0",      copro_op0,         32'd0);
      check("rst_result",   req_result,        32'd0);

      // Single request: 3F800000 + 40000000 + 1
      acc0 = accept_count;
      setreq(0, 11'h001, 32'h3F800000, 32'h40000000, 1);
      push(0, 32'h7F800001, 1'b0);
      rv[0] = 1'b1;
      step();
      check("single_valid_next", 32'(copro_valid), 32'd1);
      check("single_opcode", 32'(copro_opcode), 32'h001);
      check("single_op0", copro_op0, 32'h3F800000);
      check("single_op1", copro_op1, 32'h40000000);
      drain("single", 40);
      check("single_accepts", 32'(accept_count - acc0), 32'd1);

      // Contention from reset: 0,1,2,3,0
      do_reset();
      setreq(0, 11'h002, 32'h00000010, 32'h00000020, 2);
      setreq(1, 11'h003, 32'h00000100, 32'h00000200, 1);
      setreq(2, 11'h004, 32'h00001000, 32'h00002000, 1);
      setreq(3, 11'h005, 32'h00010000, 32'h00020000, 1);
      push(0, 32'h00000032, 1'b0);
      push(1, 32'h00000303, 1'b0);
      push(2, 32'h00003004, 1'b0);
      push(3, 32'h00030005, 1'b0);
      push(0, 32'h00000032, 1'b0);
      rv = 4'b1111;
      drain("contention", 200);

      // Rotation: 2 served, then 1 and 3 together -> 3 before 1
      setreq(2, 11'h004, 32'h00001000, 32'h00002000, 1);
      push(2, 32'h00003004, 1'b0);
      rv[2] = 1'b1;
      drain("rot2", 40);
      setreq(1, 11'h003, 32'h00000100, 32'h00000200, 1);
      setreq(3, 11'h005, 32'h00010000, 32'h00020000, 1);
      push(3, 32'h00030005, 1'b0);
      push(1, 32'h00000303, 1'b0);
      rv[1] = 1'b1;
      rv[3] = 1'b1;
      drain("rotation", 80);

      // Abandon: requester 0 drops valid during ISSUE
      acc0 = accept_count;
      setreq(0, 11'h006, 32'h00000001, 32'h00000002, 1);
      rv[0] = 1'b1;
      wait_valid("abandon");
      check("abandon_opcode", 32'(copro_opcode), 32'h006);
      rv[0] = 1'b0;
      pend[0] = 0;
      n = 0;
      bad = 0;
      while (accept_count == acc0 && n < 30) begin
         step();
         if (req_complete != '0) bad++;
         n++;
      end
      check("abandon_accepted", 32'(accept_count - acc0), 32'd1);
      repeat (4) begin
         step();
         if (req_complete != '0) bad++;
      end
      check("abandon_no_complete", 32'(bad), 32'd0);
      setreq(1, 11'h003, 32'h00000100, 32'h00000200, 1);
      push(1, 32'h00000303, 1'b0);
      rv[1] = 1'b1;
      drain("after_abandon", 40);

      // Reset during ISSUE
      setreq(2, 11'h004, 32'h00001000, 32'h00002000, 1);
      rv[2] = 1'b1;
      wait_valid("rstmid");
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_valid",    32'(copro_valid),  32'd0);
      check("rstmid_accept",   32'(copro_accept), 32'd0);
      check("rstmid_complete", 32'(req_complete), 32'd0);
      rv[2] = 1'b0;
      pend[2] = 0;
      step();
      step();
      rst_n = 1'b1;
      setreq(0, 11'h002, 32'h00000010, 32'h00000020, 1);
      setreq(2, 11'h004, 32'h00001000, 32'h00002000, 1);
      push(0, 32'h00000032, 1'b0);
      push(2, 32'h00003004, 1'b0);
      rv[0] = 1'b1;
      rv[2] = 1'b1;
      drain("rstmid", 80);

`ifdef FLOAT_COPRO_ARB_TIMEOUT_EN
      // Timeout with copro_complete stuck low
      stuck = 1'b1;
      setreq(1, 11'h003, 32'h00000100, 32'h00000200, 1);
      push(1, 32'h7FC00000, 1'b1);
      rv[1] = 1'b1;
      wait_valid("timeout");
      n = 0;
      while (copro_valid === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check("timeout_issue_cycles", 32'(n), 32'd8);
      drain("timeout", 40);
      stuck = 1'b0;
`endif

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
